// File: rtl/exec_cond_stage.sv
// Execute back end: NZCV flag register, condition evaluation, result register.
// Optional squash counter enabled by defining COND_STATS_EN.
module exec_cond_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] bus_i,
  input  logic             flag_c_i,
  input  logic             flag_n_i,
  input  logic             flag_v_i,
  input  logic             flag_z_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_write_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic             pc_src_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             pc_src_o,
`ifdef COND_STATS_EN
  output logic [15:0]      squash_count_o,
`endif
  output logic [3:0]       flags_o
);

  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       pass;
  logic       accept;

  assign {n, z, c, v} = flags_q;
  assign flags_o = flags_q;
  assign ready_o = !valid_o || ready_i;
  assign accept = valid_i && ready_o && !flush_i;

  always_comb begin
    pass = 1'b1;
    case (cond_i)
      4'd0:  pass = z;
      4'd1:  pass = !z;
      4'd2:  pass = c;
      4'd3:  pass = !c;
      4'd4:  pass = n;
      4'd5:  pass = !n;
      4'd6:  pass = v;
      4'd7:  pass = !v;
      4'd8:  pass = c && !z;
      4'd9:  pass = !c || z;
      4'd10: pass = (n == v);
      4'd11: pass = (n != v);
      4'd12: pass = !z && (n == v);
      4'd13: pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o     <= 1'b0;
      bus_o       <= '0;
      reg_write_o <= 1'b0;
      mem_write_o <= 1'b0;
      pc_src_o    <= 1'b0;
      flags_q     <= 4'b0000;
    end else if (flush_i) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      mem_write_o <= 1'b0;
      pc_src_o    <= 1'b0;
    end else if (accept) begin
      valid_o     <= 1'b1;
      bus_o       <= bus_i;
      // failed condition still occupies the slot as a bubble
      reg_write_o <= pass && reg_write_i;
      mem_write_o <= pass && mem_write_i;
      pc_src_o    <= pass && pc_src_i;
      if (pass && flag_write_i[1]) begin
        flags_q[3] <= flag_n_i;
        flags_q[2] <= flag_z_i;
      end
      if (pass && flag_write_i[0]) begin
        flags_q[1] <= flag_c_i;
        flags_q[0] <= flag_v_i;
      end
    end else if (ready_i) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      mem_write_o <= 1'b0;
      pc_src_o    <= 1'b0;
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      squash_count_o <= '0;
    end else if (accept && !pass && squash_count_o != 16'hFFFF) begin
      squash_count_o <= squash_count_o + 16'd1;
    end
  end
`endif

endmodule
